rr_mux8x1: RTL
==============

# rr_mux8x1

Eight-channel round-robin multiplexer with valid/ready handshakes on every input and a registered output stage. It is the transmit-side counterpart of the 1x8 demultiplexer: it merges eight producers onto one shared data path and drives the 3-bit select code {s2,s1,s0}, which the far-end demultiplexer uses to route each word back to its channel. Arbitration is fair: no requesting channel waits more than seven transfers.

## Interface
- WIDTH, 8, data width of each channel and of the output word
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  8  per-channel request; bit k belongs to channel k
- in_data  in  8*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_ready  out  8  one-hot (or zero) accept strobe to the granted channel
- out_valid  out  1  output word valid
- out_ready  in  1  downstream (demux side) accept
- out_data  out  WIDTH  registered word
- out_sel  out  3  registered channel code {s2,s1,s0} for out_data

## Operation
- States:
  - EMPTY: output register holds no word; out_valid=0.
  - FULL: output register holds a word; out_valid=1.
- load = (state==EMPTY) || (out_ready && out_valid).
- When load is high and any in_valid bit is set, the arbiter grants one channel g:
  - It takes the first set bit searching upward from ptr+1, modulo 8.
  - in_ready[g]=1 in the same cycle (combinational from in_valid, ptr and load); all other in_ready bits are 0.
  - On the next edge: out_data<=in_data[g], out_sel<=g, ptr<=g, state<=FULL.
- When load is high and no in_valid bit is set:
  - state<=EMPTY, out_valid drops.
  - out_data and out_sel keep their last value.
  - ptr is unchanged.
- FULL with out_ready=0: everything holds and in_ready=0.
- Producers must hold in_valid and in_data stable until in_ready. The block does not check this.
- Wrap-around: after channel 7 the search continues at channel 0.
- ptr reset value is 7, so channel 0 wins the first arbitration after reset.

## Timing
- Reset (async assert, sync deassert by the environment):
  - out_valid=0, out_data=0, out_sel=3'b000, in_ready=0, ptr=7, state=EMPTY.
- Latency is 1 cycle from in_valid&in_ready to out_valid with that word.
- Throughput is 1 word/cycle while out_ready stays high and requests are present. The output register is refilled in the same cycle it is drained.
- With all eight channels requesting continuously, the out_sel sequence is 0,1,2,…,7,0,…
- A single channel requesting continuously is served back-to-back, every cycle.
- Simultaneous drain and load: the new word replaces the old one at the same edge, and out_valid stays 1.
- Reset mid-transfer: the held word is discarded. No in_ready is issued while rst_n=0.

## Structure
- Package mux_pkg holds:
  - N_CH=8
  - SEL_W=3
  - state encoding: EMPTY=1'b0, FULL=1'b1
- Sub-module rr_arbiter8 contains only the round-robin logic:
  - inputs: req[7:0], ptr[2:0], en
  - outputs: gnt[7:0] (one-hot), gnt_idx[2:0], any
- The top level holds the state register, the output register and ptr.

## Test plan
- Reset, then in_valid=8'h01 with in_data ch0=8'hA5 and out_ready=1.
  - Required: in_ready=8'h01; next cycle out_valid=1, out_data=A5, out_sel=000.
- All channels valid with ch k data = 8'h10+k, out_ready=1 for 10 cycles.
  - Required: out_sel 0..7,0,1 and out_data 10..17,10,11 on consecutive cycles.
- Word from ch3 held in FULL with out_ready=0 for 4 cycles while ch5 requests.
  - Required: out_data and out_sel=011 stable and in_ready=0 throughout.
  - When out_ready rises: ch5 is granted that cycle; out_sel=101 on the next cycle.
- Only ch7 then only ch0 requesting, alternating.
  - Required: out_sel 111, 000, 111 across the wrap, with no idle cycle.
- rst_n pulsed low while FULL with ch2's word.
  - Required: out_valid=0 and out_sel=000 immediately (asynchronous).
  - After release with all channels requesting: channel 0 is granted first.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the 8:1 round-robin multiplexer.
// Contents:
//   N_CH     number of producer channels
//   SEL_W    width of the channel code {s2,s1,s0}
//   state_t  output-register occupancy: EMPTY (no word) / FULL (word held)
package mux_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter, purely combinational.
// Ports:
//   req      in   per-channel request
//   ptr      in   last granted channel; search starts at ptr+1
//   en       in   grant enable (output register can accept a word)
//   gnt      out  one-hot grant, zero when disabled or nothing requested
//   gnt_idx  out  index of the winning channel (valid when any=1)
//   any      out  at least one request present
module rr_arbiter8
    import mux_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic             found;
    logic [SEL_W-1:0] cand;

    // Candidate index wraps naturally in SEL_W bits; the last step (i=N_CH)
    // revisits ptr itself, so a lone requester on ptr still wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign any = |req;
    assign gnt = (en && any) ? (N_CH'(1) << gnt_idx) : '0;

endmodule

// File: rtl/rr_mux8x1.sv
// Eight-channel round-robin multiplexer with a registered output stage.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   in_valid    per-channel request
//   in_data     channel k data in bits [k*WIDTH +: WIDTH]
//   in_ready    one-hot accept strobe to the granted channel
//   out_valid   output register holds a word
//   out_ready   downstream accept
//   out_data    registered word
//   out_sel     registered channel code {s2,s1,s0} for out_data
//
// state | meaning
// EMPTY | output register holds no word, out_valid=0
// FULL  | output register holds a word, out_valid=1
module rr_mux8x1
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               load;
    logic [N_CH-1:0]    gnt;
    logic [SEL_W-1:0]   gnt_idx;
    logic               any;

    // The register can take a new word when empty or when it is drained
    // this very cycle, which gives one word per cycle under full flow.
    assign load = (state_q == EMPTY) || (out_ready && out_valid);

    // Gating with rst_n keeps in_ready low while reset is held, even though
    // the state register reads EMPTY during that time.
    rr_arbiter8 u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .en      (load && rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(N_CH - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (any) begin
                state_d = FULL;
                data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
                sel_d   = gnt_idx;
                ptr_d   = gnt_idx;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    assign in_ready  = gnt;
    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule
